mem_stage_cache: RTL
====================

Name: mem_stage_cache

Overview:
Parametrised successor to the pipeline MEM stage. It puts a direct-mapped, write-through, no-write-allocate data cache in front of a variable-latency backing memory reached over a req/ack handshake. It raises a pipeline stall on misses and writes, and keeps the sprite/ALU result mux and branch-condition evaluation. It sits between EX/MEM and MEM/WB pipeline registers; the backing-memory port connects to the main memory arbiter.

Parameters:
DATA_W, 32, data word width
ADDR_W, 22, word address width
IDX_W, 4, cache index bits; LINES = 2**IDX_W; legal range 1..(ADDR_W-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
re  in  1  load request
we  in  1  store request; wins over re if both high
addr  in  ADDR_W  word address; index = addr[IDX_W-1:0], tag = addr[ADDR_W-1:IDX_W]
mem_data  in  DATA_W  store data
ALU_result  in  DATA_W  ALU output
sprite_data  in  DATA_W  sprite unit output
sprite_ALU_select  in  1  1 selects sprite_data
flag_ov, flag_neg, flag_zero  in  1 each  EX flags
branch_condition  in  3  condition code
bm_req  out  1  backing memory request, registered
bm_we  out  1  backing write, registered
bm_addr  out  ADDR_W  registered
bm_wdata  out  DATA_W  registered
bm_ack  in  1  one-cycle completion strobe
bm_rdata  in  DATA_W  valid when bm_ack and read
stall  out  1  freeze upstream pipeline, combinational
mem_result  out  DATA_W  load data, registered
cache_hit  out  1  registered; 1 if the last completed access hit
sprite_ALU_result  out  DATA_W  combinational mux
branch_taken  out  1  combinational

Behaviour:
- Reset (async): state=IDLE, all valid bits 0, bm_req/bm_we=0, bm_addr/bm_wdata=0, mem_result=0, cache_hit=0. Tag/data arrays are not reset. Reset mid-transaction abandons it; a late bm_ack arriving in IDLE is ignored.
- FSM states: IDLE, FILL, WRITE.
- hit = valid[idx] & (tag_arr[idx]==tag), evaluated combinationally in IDLE.
- IDLE, re & !we & hit: stall=0. At the edge: mem_result<=data_arr[idx], cache_hit<=1. Latency is one cycle, same as the prior BRAM stage.
- IDLE, re & !we & !hit: stall=1. At the edge: bm_req<=1, bm_we<=0, bm_addr<=addr, go to FILL.
- IDLE, we: stall=1. At the edge: bm_req<=1, bm_we<=1, bm_addr<=addr, bm_wdata<=mem_data, cache_hit<=hit, go to WRITE.
- IDLE, no request: stall=0; mem_result and cache_hit hold.
- FILL/WRITE: stall = !bm_ack. bm_req stays 1 until the edge on which bm_ack is sampled, then clears. The state returns to IDLE on that same edge, so the pipeline advances exactly once per access.
- FILL on ack: valid[idx]<=1, tag_arr<=tag, data_arr<=bm_rdata, mem_result<=bm_rdata, cache_hit<=0.
- WRITE on ack: if the latched hit is 1, data_arr[idx]<=bm_wdata; no allocate on a miss. mem_result holds.
- Upstream holds addr/data stable while stall=1; the block indexes with bm_addr in FILL/WRITE.
- bm_ack in the first FILL/WRITE cycle is legal; minimum miss/write cost is 2 cycles.
- sprite_ALU_result = sprite_ALU_select ? sprite_data : ALU_result.
- branch_taken by condition code:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z&!N
  - 011 LT: N
  - 100 GTE: !N
  - 101 LTE: N|Z
  - 110 OVFL: V
  - 111 UNCOND: 1

Decomposition:
- Shared package mem_pkg: branch-condition localparams (NEQ..UNCOND), FSM state encoding, default widths.
- Sub-module mem_cache_array: valid flops (async reset), tag and data RAM, one write port, combinational read on index, hit output.
- FSM, handshake, muxes and branch logic stay in the top module.

Test Plan:
- Cold read addr=0x00005 -> stall=1 until bm_ack; bm_addr=0x00005, bm_we=0. bm_rdata=0xDEADBEEF -> mem_result=0xDEADBEEF, cache_hit=0. Repeat read -> stall=0, 1-cycle result, cache_hit=1.
- Conflict read 0x00015 (same idx 5, new tag) -> miss and refill; a subsequent read of 0x00005 misses again.
- Write 0x00005 data 0x12345678 after fill -> bm_we=1, bm_wdata=0x12345678, cache_hit=1; next read hits with 0x12345678. Write to uncached 0x00007 -> the next read of 0x00007 misses.
- re=we=1 on addr 0x00009 -> treated as a write; no fill issued.
- Reset asserted during FILL -> bm_req=0 immediately; later bm_ack ignored; read of the same address misses.
- Sweep branch_condition 0..7 against all 8 Z/N/V combinations -> matches the table. sprite_ALU_select=1/0 selects 0xAAAA0000 / 0x0000BBBB.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants for the cached MEM stage
package mem_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 22;
   localparam int DEF_IDX_W  = 4;

   localparam logic [2:0] BR_NEQ    = 3'b000;
   localparam logic [2:0] BR_EQ     = 3'b001;
   localparam logic [2:0] BR_GT     = 3'b010;
   localparam logic [2:0] BR_LT     = 3'b011;
   localparam logic [2:0] BR_GTE    = 3'b100;
   localparam logic [2:0] BR_LTE    = 3'b101;
   localparam logic [2:0] BR_OVFL   = 3'b110;
   localparam logic [2:0] BR_UNCOND = 3'b111;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;

   function automatic logic branch_eval(input logic [2:0] cond,
                                        input logic z,
                                        input logic n,
                                        input logic v);
      logic taken;
      taken = 1'b0;
      case (cond)
         BR_NEQ:    taken = !z;
         BR_EQ:     taken = z;
         BR_GT:     taken = !z && !n;
         BR_LT:     taken = n;
         BR_GTE:    taken = !n;
         BR_LTE:    taken = n || z;
         BR_OVFL:   taken = v;
         default:   taken = 1'b1;
      endcase
      return taken;
   endfunction

endpackage

// File: rtl/mem_cache_array.sv
// rtl/mem_cache_array.sv - direct-mapped valid/tag/data store with one write port
module mem_cache_array
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int IDX_W  = DEF_IDX_W,
   parameter int TAG_W  = DEF_ADDR_W - DEF_IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic [DATA_W-1:0] rd_data,
   output logic              hit,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data
);

   localparam int LINES = 1 << IDX_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_arr  [LINES];
   logic [DATA_W-1:0] data_arr [LINES];

   // Only valid bits are reset; stale tag/data is masked by valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_arr[wr_idx]  <= wr_tag;
         data_arr[wr_idx] <= wr_data;
      end
   end

   assign hit     = valid[rd_idx] && (tag_arr[rd_idx] == rd_tag);
   assign rd_data = data_arr[rd_idx];

endmodule

// File: rtl/mem_stage_cache.sv
// rtl/mem_stage_cache.sv - MEM stage with write-through direct-mapped data cache
module mem_stage_cache
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int IDX_W  = DEF_IDX_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] ALU_result,
   input  logic [DATA_W-1:0] sprite_data,
   input  logic              sprite_ALU_select,
   input  logic              flag_ov,
   input  logic              flag_neg,
   input  logic              flag_zero,
   input  logic [2:0]        branch_condition,
   output logic              bm_req,
   output logic              bm_we,
   output logic [ADDR_W-1:0] bm_addr,
   output logic [DATA_W-1:0] bm_wdata,
   input  logic              bm_ack,
   input  logic [DATA_W-1:0] bm_rdata,
   output logic              stall,
   output logic [DATA_W-1:0] mem_result,
   output logic              cache_hit,
   output logic [DATA_W-1:0] sprite_ALU_result,
   output logic              branch_taken
);

   localparam int TAG_W = ADDR_W - IDX_W;

   logic [1:0]        state;
   logic              wr_hit;
   logic              hit;
   logic [DATA_W-1:0] rd_data;
   logic [ADDR_W-1:0] look_addr;
   logic              arr_wr_en;
   logic [DATA_W-1:0] arr_wr_data;
   logic              ack_fill;
   logic              ack_write;

   // Upstream holds addr while stalled, but bm_addr is the authoritative copy.
   assign look_addr   = (state == ST_IDLE) ? addr : bm_addr;
   assign ack_fill    = (state == ST_FILL)  && bm_ack;
   assign ack_write   = (state == ST_WRITE) && bm_ack;
   assign arr_wr_en   = ack_fill || (ack_write && wr_hit);
   assign arr_wr_data = ack_fill ? bm_rdata : bm_wdata;

   mem_cache_array #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W)
   ) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd_idx  (look_addr[IDX_W-1:0]),
      .rd_tag  (look_addr[ADDR_W-1:IDX_W]),
      .rd_data (rd_data),
      .hit     (hit),
      .wr_en   (arr_wr_en),
      .wr_idx  (bm_addr[IDX_W-1:0]),
      .wr_tag  (bm_addr[ADDR_W-1:IDX_W]),
      .wr_data (arr_wr_data)
   );

   always_comb begin
      stall = 1'b0;
      case (state)
         ST_IDLE:  stall = we || (re && !hit);
         ST_FILL,
         ST_WRITE: stall = !bm_ack;
         default:  stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         wr_hit     <= 1'b0;
         bm_req     <= 1'b0;
         bm_we      <= 1'b0;
         bm_addr    <= '0;
         bm_wdata   <= '0;
         mem_result <= '0;
         cache_hit  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (we) begin
                  bm_req    <= 1'b1;
                  bm_we     <= 1'b1;
                  bm_addr   <= addr;
                  bm_wdata  <= mem_data;
                  cache_hit <= hit;
                  wr_hit    <= hit;
                  state     <= ST_WRITE;
               end else if (re && hit) begin
                  mem_result <= rd_data;
                  cache_hit  <= 1'b1;
               end else if (re) begin
                  bm_req  <= 1'b1;
                  bm_we   <= 1'b0;
                  bm_addr <= addr;
                  state   <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (bm_ack) begin
                  bm_req     <= 1'b0;
                  mem_result <= bm_rdata;
                  cache_hit  <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            ST_WRITE: begin
               if (bm_ack) begin
                  bm_req <= 1'b0;
                  bm_we  <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign sprite_ALU_result = sprite_ALU_select ? sprite_data : ALU_result;
   assign branch_taken      = branch_eval(branch_condition, flag_zero, flag_neg, flag_ov);

endmodule
